// File: rtl/sram_arbiter_pkg.sv
// ============================================================================
// sram_arbiter_pkg : shared types and port IDs for the SRAM arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package sram_arbiter_pkg;

  localparam int NUM_PORTS = 3;

  localparam logic [1:0] PORT_VGA  = 2'd0;
  localparam logic [1:0] PORT_US   = 2'd1;
  localparam logic [1:0] PORT_IDCT = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_P0   = 2'd1,
    ARB_P1   = 2'd2,
    ARB_P2   = 2'd3
  } arb_owner_type;

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } ret_slot_t;

  function automatic arb_owner_type port_to_owner(input logic [1:0] id);
    arb_owner_type o;
    case (id)
      PORT_VGA: o = ARB_P0;
      PORT_US:  o = ARB_P1;
      default:  o = ARB_P2;
    endcase
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_arb_return_pipe.sv
// ============================================================================
// sram_arb_return_pipe : READ_LATENCY-deep {valid, id} shift register that
// tags read returns with the issuing port. Revision: 1.0
// ============================================================================
`default_nettype none

module sram_arb_return_pipe
  import sram_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 load_valid_i,
  input  logic [1:0]           load_id_i,
  output logic [NUM_PORTS-1:0] rvalid_o
);

  ret_slot_t slot_q [READ_LATENCY];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < READ_LATENCY; i++) slot_q[i] <= '0;
    end else begin
      slot_q[0] <= '{valid: load_valid_i, id: load_id_i};
      for (int i = 1; i < READ_LATENCY; i++) slot_q[i] <= slot_q[i-1];
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (slot_q[READ_LATENCY-1].valid)
      rvalid_o = NUM_PORTS'(1) << slot_q[READ_LATENCY-1].id;
  end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// sram_arbiter : fixed-priority (VGA) plus round-robin/burst arbitration of
// one SRAM port among three requesters, with tagged read return.
// Optional statistics counters: define SRAM_ARB_STATS_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 8,
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [NUM_PORTS-1:0] Req,
  input  logic [NUM_PORTS-1:0] Req_we_n,
  input  logic [ADDR_W-1:0]    Req_address    [NUM_PORTS-1:0],
  input  logic [DATA_W-1:0]    Req_write_data [NUM_PORTS-1:0],
  output logic [NUM_PORTS-1:0] Gnt,
  output logic [NUM_PORTS-1:0] Rvalid,
  output logic [DATA_W-1:0]    Rdata,
  output logic [ADDR_W-1:0]    SRAM_address,
  output logic [DATA_W-1:0]    SRAM_write_data,
  output logic                 SRAM_we_n,
  input  logic [DATA_W-1:0]    SRAM_read_data,
  output logic [15:0]          Stat_grants    [NUM_PORTS-1:0],
  output logic [15:0]          Stat_stalls
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  arb_owner_type owner_q, owner_d;
  logic [7:0]    burst_cnt_q, burst_cnt_d;
  logic [1:0]    rr_last_q, rr_last_d;

  logic [NUM_PORTS-1:0] req_eff;
  logic                 gnt_any;
  logic [1:0]           gnt_id;
  logic                 own_low;
  logic [1:0]           own_id;

  // Requests are masked while reset is held so the SRAM side stays idle.
  assign req_eff = Resetn ? Req : '0;
  assign own_low = (owner_q == ARB_P1) || (owner_q == ARB_P2);
  assign own_id  = (owner_q == ARB_P2) ? PORT_IDCT : PORT_US;

  always_comb begin
    gnt_any     = 1'b0;
    gnt_id      = PORT_VGA;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rr_last_d   = rr_last_q;

    if (req_eff[PORT_VGA]) begin
      gnt_any = 1'b1;
      gnt_id  = PORT_VGA;
    end else if (own_low && req_eff[own_id] && (burst_cnt_q < MAX_BURST_C)) begin
      gnt_any = 1'b1;
      gnt_id  = own_id;
    end else if (req_eff[PORT_US] && req_eff[PORT_IDCT]) begin
      gnt_any = 1'b1;
      gnt_id  = (rr_last_q == PORT_US) ? PORT_IDCT : PORT_US;
    end else if (req_eff[PORT_US]) begin
      gnt_any = 1'b1;
      gnt_id  = PORT_US;
    end else if (req_eff[PORT_IDCT]) begin
      gnt_any = 1'b1;
      gnt_id  = PORT_IDCT;
    end

    if (!gnt_any) begin
      owner_d     = ARB_IDLE;
      burst_cnt_d = 8'd0;
    end else if (gnt_id == PORT_VGA) begin
      // Preemption keeps the low-priority owner and its count so it resumes.
      owner_d = own_low ? owner_q : ARB_P0;
    end else begin
      owner_d     = port_to_owner(gnt_id);
      burst_cnt_d = (owner_d == owner_q)
                  ? ((burst_cnt_q == 8'hFF) ? 8'hFF : burst_cnt_q + 8'd1)
                  : 8'd1;
      rr_last_d   = gnt_id;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      owner_q     <= ARB_IDLE;
      burst_cnt_q <= 8'd0;
      rr_last_q   <= PORT_IDCT;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign Gnt             = gnt_any ? (NUM_PORTS'(1) << gnt_id) : '0;
  assign SRAM_address    = gnt_any ? Req_address[gnt_id]    : '0;
  assign SRAM_write_data = gnt_any ? Req_write_data[gnt_id] : '0;
  assign SRAM_we_n       = gnt_any ? Req_we_n[gnt_id]       : 1'b1;
  assign Rdata           = SRAM_read_data;

  sram_arb_return_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_return_pipe (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .load_valid_i (gnt_any && Req_we_n[gnt_id]),
    .load_id_i    (gnt_id),
    .rvalid_o     (Rvalid)
  );

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] stat_grants_q [NUM_PORTS-1:0];
  logic [15:0] stat_stalls_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NUM_PORTS; i++) stat_grants_q[i] <= 16'd0;
      stat_stalls_q <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (Gnt[i]) stat_grants_q[i] <= stat_grants_q[i] + 16'd1;
      if ((req_eff & ~Gnt) != '0) stat_stalls_q <= stat_stalls_q + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat_out
    assign Stat_grants[g] = stat_grants_q[g];
  end
  assign Stat_stalls = stat_stalls_q;
`else
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat_zero
    assign Stat_grants[g] = 16'd0;
  end
  assign Stat_stalls = 16'd0;
`endif

endmodule

`default_nettype wire
